// File: rtl/frame_sequencer_pkg.sv
// frame_sequencer_pkg: shared state type and sizing constants for the frame sequencer
package frame_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  localparam int PIXEL_SIZE = 24;
  localparam int DEF_FRAME_WIDTH = 640;
  localparam int DEF_FRAME_HEIGHT = 480;
  localparam int COORD_W = 16;
endpackage

// File: rtl/frame_sequencer_raster_counter.sv
// raster_counter: x/y raster position with enable, clear and end-of-row/end-of-frame flags
module raster_counter
  import frame_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_FRAME_WIDTH,
  parameter int HEIGHT = DEF_FRAME_HEIGHT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               en,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last_col,
  output logic               last_pixel
);
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic last_row;
  assign last_col = x_q == COORD_W'(WIDTH - 1);
  assign last_row = y_q == COORD_W'(HEIGHT - 1);
  assign last_pixel = last_col & last_row;
  assign x = x_q;
  assign y = y_q;
  always_comb begin
    x_d = clear ? '0 : !en ? x_q : last_col ? '0 : x_q + COORD_W'(1);
    y_d = clear ? '0 : !(en & last_col) ? y_q : last_row ? '0 : y_q + COORD_W'(1);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: feeds the pixel pipeline from a valid/ready source, flushes after each frame, tags valid results.
// Define FRAME_SEQ_STATS_EN to add the frame_count/stall_count statistics outputs.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int FRAME_WIDTH = DEF_FRAME_WIDTH,
  parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
  parameter int LATENCY = FRAME_WIDTH + 2,
  parameter int CNT_W = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PIXEL_SIZE-1:0] s_data,
  output logic                  pix_en,
  output logic                  pix_hsync,
  output logic                  pix_vsync,
  output logic [PIXEL_SIZE-1:0] pix_data,
  output logic                  out_valid,
  output logic [COORD_W-1:0]    out_x,
  output logic [COORD_W-1:0]    out_y,
  output logic                  frame_done,
  output logic                  busy
`ifdef FRAME_SEQ_STATS_EN
  ,
  output logic [15:0]           frame_count,
  output logic [31:0]           stall_count
`endif
);
  if (FRAME_WIDTH < 2 || FRAME_HEIGHT < 2 || FRAME_WIDTH > 2**COORD_W || FRAME_HEIGHT > 2**COORD_W ||
      LATENCY < 1 || CNT_W < 1 || CNT_W > 62 ||
      longint'(FRAME_WIDTH) * longint'(FRAME_HEIGHT) + longint'(LATENCY) >= (longint'(1) << CNT_W)) begin : g_bad_params
    $error("frame_sequencer: illegal FRAME_WIDTH/FRAME_HEIGHT/LATENCY/CNT_W");
  end
  state_t state_q, state_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d, fill_cnt_q, fill_cnt_d;
  logic [PIXEL_SIZE-1:0] pix_data_q, pix_data_d;
  logic pix_en_q, pix_en_d, pix_hsync_q, pix_hsync_d, pix_vsync_q, pix_vsync_d;
  logic frame_done_q, frame_done_d;
  logic hs, flush_last;
  logic in_last_col, in_last_pixel, out_last_pixel, unused_out_last_col;
  logic [COORD_W-1:0] unused_in_x, unused_in_y;
  raster_counter #(.WIDTH(FRAME_WIDTH), .HEIGHT(FRAME_HEIGHT)) u_in_pos (
    .clk(clk), .reset_n(reset_n), .clear(1'b0), .en(hs),
    .x(unused_in_x), .y(unused_in_y), .last_col(in_last_col), .last_pixel(in_last_pixel)
  );
  raster_counter #(.WIDTH(FRAME_WIDTH), .HEIGHT(FRAME_HEIGHT)) u_out_pos (
    .clk(clk), .reset_n(reset_n), .clear(frame_done_d), .en(out_valid),
    .x(out_x), .y(out_y), .last_col(unused_out_last_col), .last_pixel(out_last_pixel)
  );
  always_comb begin
    s_ready = reset_n & (state_q != FLUSH);
    hs = s_valid & s_ready;
    flush_last = (state_q == FLUSH) && (flush_cnt_q == CNT_W'(LATENCY - 1));
    state_d = state_q == FLUSH ? (flush_last ? IDLE : FLUSH) : hs ? (in_last_pixel ? FLUSH : RUN) : state_q;
    flush_cnt_d = (state_q == FLUSH && !flush_last) ? flush_cnt_q + CNT_W'(1) : '0;
    pix_en_d = hs | (state_q == FLUSH);
    pix_data_d = hs ? s_data : (state_q == FLUSH) ? '0 : pix_data_q;
    pix_hsync_d = hs & in_last_col & ~in_last_pixel;
    pix_vsync_d = hs & in_last_pixel;
    out_valid = pix_en_q & (fill_cnt_q >= CNT_W'(LATENCY));
    // the final flush cycle carries the frame's last result, so it also ends the frame
    frame_done_d = out_valid & out_last_pixel;
    fill_cnt_d = frame_done_d ? '0 : fill_cnt_q + CNT_W'(pix_en_q);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      flush_cnt_q <= '0;
      fill_cnt_q <= '0;
      pix_en_q <= 1'b0;
      pix_hsync_q <= 1'b0;
      pix_vsync_q <= 1'b0;
      pix_data_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_cnt_q <= flush_cnt_d;
      fill_cnt_q <= fill_cnt_d;
      pix_en_q <= pix_en_d;
      pix_hsync_q <= pix_hsync_d;
      pix_vsync_q <= pix_vsync_d;
      pix_data_q <= pix_data_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign pix_en = pix_en_q;
  assign pix_hsync = pix_hsync_q;
  assign pix_vsync = pix_vsync_q;
  assign pix_data = pix_data_q;
  assign frame_done = frame_done_q;
  assign busy = state_q != IDLE;
`ifdef FRAME_SEQ_STATS_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic [31:0] stall_count_q, stall_count_d;
  always_comb begin
    frame_count_d = frame_count_q + 16'(frame_done_d);
    stall_count_d = stall_count_q + 32'(state_q == RUN && !s_valid && stall_count_q != '1);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
      stall_count_q <= stall_count_d;
    end
  end
  assign frame_count = frame_count_q;
  assign stall_count = stall_count_q;
`endif
endmodule
